// File: rtl/ram_sync_p.sv
// ram_sync_p: parametrised synchronous single-port RAM with a request handshake,
// a registered read path (1-cycle latency, rd_valid strobe) and a clear engine
// that writes INIT_VAL to every word after reset or when clear is pulsed.
// Ports: clk/reset (async, active high); cs/wr/addr/data_in request, accepted
// when cs && ready; clear starts a sweep; data_out/rd_valid read return;
// err flags an accepted out-of-range access; clr_done marks the end of a sweep.
module ram_sync_p #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 16,
    parameter int                 DEPTH    = 65536,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              err,
    output logic              clr_done
);

    // Index width covers only the implemented words; DEPTH fits in ADDR_W+1 bits.
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              sweep_last;
    logic              rd_acc;
    logic              wr_acc;
    logic              oob_acc;
    logic [IDX_W-1:0]  addr_idx;

    // Out-of-range addresses are rejected rather than aliased onto low words.
    assign in_range   = {1'b0, addr} < DEPTH_X;
    assign addr_idx   = addr[IDX_W-1:0];
    assign sweep_last = (state == S_CLEAR) && (clr_addr == LAST_IDX);

    assign rd_acc  = cs && ready && !wr && in_range;
    assign wr_acc  = cs && ready &&  wr && in_range;
    assign oob_acc = cs && ready && !in_range;

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            S_CLEAR: begin
                if (clr_addr == LAST_IDX) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                // A clear request pre-empts any access offered in the same cycle.
                ready = !clear;
                if (clear) begin
                    state_nxt = S_CLEAR;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= rd_acc;
            err      <= oob_acc;
            clr_done <= sweep_last;
            if (state == S_CLEAR && !sweep_last) begin
                clr_addr <= clr_addr + 1'b1;
            end else begin
                clr_addr <= '0;
            end
            // data_out only moves on a valid read; clear and errors leave it alone.
            if (rd_acc) begin
                data_out <= mem[addr_idx];
            end
        end
    end

    // Storage has no reset: the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (wr_acc) begin
            mem[addr_idx] <= data_in;
        end
    end

endmodule
